board_input_reader: RTL and testbench
=====================================

# board_input_reader

Memory-mapped input peripheral for the DIP-switch bank and the user push-keys. It is the read-side counterpart of the seven-segment display output device. It synchronizes and debounces 64 switch inputs and 8 key inputs, and exposes the debounced levels to the CPU through a small register window. It latches key-press and switch-change events into sticky flags and raises a level interrupt toward the CPU's interrupt controller.

## Interface
- `DB_CYCLES`, default 20000: prescaler period in clk cycles between debounce samples; legal range ≥ 2.
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `we` in 1: write strobe from system bridge, valid with `addr`.
- `addr` in 3: word address within peripheral window.
- `din` in 32: write data.
- `dout` in 32: read data, combinational from `addr` and register state.
- `dip_sw` in 64: raw switch inputs, active-low (0 = switch on), asynchronous to `clk`.
- `user_key` in 8: raw key inputs, active-low (0 = pressed), asynchronous.
- `irq` out 1: registered interrupt request, level, active-high.

## Operation
- Inputs are inverted at entry, so internal 1 means on or pressed.
- Each of the 72 bits passes through a 2-flop synchronizer (`s`).
- Prescaler: counts 0..DB_CYCLES-1, then wraps. `tick` is high in the cycle where count == DB_CYCLES-1.
- Per bit, a 2-deep history `h[1:0]` is kept. On each tick edge, `h <= {h[0], s}`.
  - If `h[1] == h[0] == s` at that edge, the debounced value `deb <= s`.
  - A level must therefore be sampled identically on 3 consecutive ticks to be accepted.
  - Bounce shorter than 2 tick periods never reaches `deb`.
- `deb_prev` holds `deb` delayed by one cycle, for edge detection.
- Register map, read via `dout`:
  - 0 SW_LO: `deb_sw[31:0]`.
  - 1 SW_HI: `deb_sw[63:32]`.
  - 2 KEY: `{24'b0, deb_key}`.
  - 3 EVT: `{23'b0, sw_chg, key_evt[7:0]}`.
  - 4 CTRL: `{31'b0, irq_en}`.
  - 5–7: read 0.
- Writes:
  - Addr 3: write-1-to-clear, using `din[8:0]`.
  - Addr 4: `irq_en <= din[0]`.
  - Writes to addr 0–2 and 5–7 are ignored.
- `key_evt[i]` is set in the cycle after `deb_key[i]` rises 0→1. Key releases produce no event.
- `sw_chg` is set in the cycle after any `deb_sw` bit changes, in either direction.
- Set and W1C on the same bit in the same cycle: set wins, and the bit stays 1.
- `irq <= irq_en & (|key_evt | sw_chg)`. It is registered, so it follows flag changes by one cycle.
- Inputs already active at reset release are debounced normally after reset. They produce the corresponding events, and software clears them at init.

## Timing
- Reset (async, immediate): sync flops, history, `deb`, `deb_prev`, prescaler, EVT, `irq_en` and `irq` all go to 0. With inputs idle-high, `dout` reads 0 at every address.
- Acceptance latency for a clean input change: 2 cycles of synchronizer, plus 2–3 tick periods. The maximum is 2 + 3·DB_CYCLES cycles from raw change to `deb` update.
- Event-flag latency: 1 cycle after the `deb` change.
- `irq` latency: 1 cycle after the flag set.
- W1C latency: the flag reads 0 on the cycle after the write edge. `irq` deasserts one cycle after that, if no other flag is set.
- Writing CTRL with `irq_en = 0` drops `irq` on the next edge. Flags are retained.
- `dout` is combinational, with no read side effects. Reads never clear flags.
- Prescaler wrap: the count goes DB_CYCLES-1 → 0 with no idle cycle.

## Test plan
Run all scenarios with `DB_CYCLES = 4`.
- **Reset idle:** assert `rst` with `dip_sw = 64'hFFFF_FFFF_FFFF_FFFF` and `user_key = 8'hFF`, then release. Reads of addr 0–7 all return 0. `irq = 0`.
- **Clean switch:** drive `dip_sw[0]` low. SW_LO becomes 0x1 within 14 cycles and no earlier than 10. EVT becomes 0x100. `irq` stays 0 (`irq_en = 0`).
- **Bouncing key:** set CTRL = 1, toggle `user_key[3]` every 3 cycles for 40 cycles, then hold it low. KEY bit 3 rises exactly once. EVT = 0x008. `irq = 1` one cycle after the EVT set.
- **W1C with a simultaneous event:** time the write of 0x108 to EVT to land on the same edge where `key_evt[5]` sets. EVT then reads 0x020, and `irq` stays 1. Writing 0x020 next gives EVT = 0, and `irq` falls 1 cycle later.
- **Release and switch-off:** release key 3, then return `dip_sw[0]` high. KEY = 0 and no key event occurs. SW_LO = 0 and `sw_chg` sets.
- **Reset mid-debounce:** assert `rst` midway through a key's history fill. All outputs are 0 immediately, and the key must then accumulate 3 fresh agreeing ticks before KEY updates.

Source files
------------

// File: rtl/board_input_reader.sv
// Memory-mapped DIP-switch / push-key reader: sync, debounce, sticky
// event flags and a level interrupt toward the CPU.
module board_input_reader #(
    parameter int DB_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [63:0] dip_sw,
    input  logic [7:0]  user_key,
    output logic        irq
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // Bit layout of all 72-bit vectors: [63:0] switches, [71:64] keys.
    logic [71:0] raw;
    logic [71:0] sync1;
    logic [71:0] s;
    logic [71:0] h0;
    logic [71:0] h1;
    logic [71:0] deb;
    logic [71:0] deb_prev;
    logic [71:0] agree_hi;
    logic [71:0] agree_lo;
    logic [CW-1:0] cnt;
    logic        tick;

    logic [7:0]  key_evt;
    logic        sw_chg;
    logic        irq_en;
    logic [7:0]  key_rise;
    logic        sw_change;
    logic        evt_we;
    logic [8:0]  clr;
    logic        unused_din;

    assign raw  = ~{user_key, dip_sw};
    assign tick = (cnt == CNT_LAST);

    // A level is accepted only when history and current sample agree.
    assign agree_hi = h1 & h0 & s;
    assign agree_lo = ~(h1 | h0 | s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            s        <= '0;
            h0       <= '0;
            h1       <= '0;
            deb      <= '0;
            deb_prev <= '0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            s        <= sync1;
            deb_prev <= deb;
            cnt      <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                h1  <= h0;
                h0  <= s;
                deb <= agree_hi | (deb & ~agree_lo);
            end
        end
    end

    assign key_rise  = deb[71:64] & ~deb_prev[71:64];
    assign sw_change = |(deb[63:0] ^ deb_prev[63:0]);
    assign evt_we    = we && (addr == 3'd3);
    assign clr       = evt_we ? din[8:0] : 9'd0;
    assign unused_din = ^din[31:9];

    // New events are OR-ed in after the clear so a same-cycle set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_evt <= '0;
            sw_chg  <= 1'b0;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            key_evt <= (key_evt & ~clr[7:0]) | key_rise;
            sw_chg  <= (sw_chg & ~clr[8]) | sw_change;
            if (we && (addr == 3'd4)) begin
                irq_en <= din[0];
            end
            irq <= irq_en & ((|key_evt) | sw_chg);
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            3'd0:    dout = deb[31:0];
            3'd1:    dout = deb[63:32];
            3'd2:    dout = {24'b0, deb[71:64]};
            3'd3:    dout = {23'b0, sw_chg, key_evt};
            3'd4:    dout = {31'b0, irq_en};
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_board_input_reader.sv
// Bench for board_input_reader: directed scenarios plus random traffic
// against a run-length debounce reference model.
module tb_board_input_reader;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [63:0] dip_sw = '1;
    logic [7:0]  user_key = '1;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    board_input_reader #(.DB_CYCLES(DB)) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .addr(addr),
        .din(din),
        .dout(dout),
        .dip_sw(dip_sw),
        .user_key(user_key),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: raw delay line, per-bit run length of equal
    // tick samples, accepted level once a run reaches 3.
    int          m_cnt;
    logic [71:0] m_dl1, m_dl2, m_last, m_deb, m_deb_d;
    int          m_run[72];
    logic [7:0]  m_kev;
    logic        m_swc, m_en, m_irq;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_deb[31:0];
            3'd1:    return m_deb[63:32];
            3'd2:    return {24'b0, m_deb[71:64]};
            3'd3:    return {23'b0, m_swc, m_kev};
            3'd4:    return {31'b0, m_en};
            default: return 32'b0;
        endcase
    endfunction

    task automatic m_reset();
        m_cnt = 0;
        m_dl1 = '0; m_dl2 = '0; m_last = '0;
        m_deb = '0; m_deb_d = '0;
        for (int i = 0; i < 72; i++) m_run[i] = 2;
        m_kev = '0; m_swc = 1'b0; m_en = 1'b0; m_irq = 1'b0;
    endtask

    task automatic step(input logic w, input logic [2:0] a,
                        input logic [31:0] d);
        logic [71:0] raw, n_deb, n_last;
        int          n_run[72];
        logic [8:0]  clr;
        logic [7:0]  rise;
        logic        chg, tk;
        we = w; addr = a; din = d;
        raw = ~{user_key, dip_sw};
        tk = (m_cnt == DB - 1);
        n_deb = m_deb; n_last = m_last; n_run = m_run;
        if (tk) begin
            for (int i = 0; i < 72; i++) begin
                if (m_dl2[i] == m_last[i])
                    n_run[i] = (m_run[i] >= 3) ? 3 : m_run[i] + 1;
                else
                    n_run[i] = 1;
                n_last[i] = m_dl2[i];
                if (n_run[i] >= 3) n_deb[i] = m_dl2[i];
            end
        end
        rise = m_deb[71:64] & ~m_deb_d[71:64];
        chg  = (m_deb[63:0] != m_deb_d[63:0]);
        clr  = (w && a == 3'd3) ? d[8:0] : 9'd0;
        @(posedge clk);
        #1;
        m_irq = m_en & ((m_kev != 0) | m_swc);
        m_kev = (m_kev & ~clr[7:0]) | rise;
        m_swc = (m_swc & ~clr[8]) | chg;
        if (w && a == 3'd4) m_en = d[0];
        m_cnt = tk ? 0 : m_cnt + 1;
        m_dl2 = m_dl1; m_dl1 = raw;
        m_deb_d = m_deb; m_deb = n_deb;
        m_last = n_last; m_run = n_run;
        check($sformatf("dout@%0d", a), dout, m_read(a));
        check("irq", {31'b0, irq}, {31'b0, m_irq});
        we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            #1;
            check($sformatf("rst_rd@%0d", a), dout, 32'h0);
        end
        check("rst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        addr = '0;
    endtask

    initial begin
        int lat, rises, evt_cyc, irq_cyc;
        logic prev, hit;

        // Reset with idle inputs
        dip_sw = '1;
        user_key = '1;
        do_reset();

        // Clean switch press
        dip_sw[0] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step(0, 3'd0, 0);
            if (lat < 0 && dout[0]) lat = i;
        end
        check("sw_lat_min", {31'b0, lat >= 10}, 32'h1);
        check("sw_lat_max", {31'b0, lat >= 0 && lat <= 14}, 32'h1);
        step(0, 3'd3, 0);
        check("evt_sw", dout, 32'h100);
        check("irq_off", {31'b0, irq}, 32'h0);

        // Bouncing key 3 with interrupts enabled
        step(1, 3'd3, 32'h1ff);
        step(1, 3'd4, 32'h1);
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) user_key[3] = ~user_key[3];
            step(0, 3'd2, 0);
            if (dout[3] && !prev) rises++;
            prev = dout[3];
        end
        check("bounce_rises", rises, 0);
        user_key[3] = 1'b0;
        evt_cyc = -1;
        irq_cyc = -1;
        for (int i = 0; i < 25; i++) begin
            step(0, 3'd3, 0);
            if (evt_cyc < 0 && dout[3]) evt_cyc = i;
            if (irq_cyc < 0 && irq) irq_cyc = i;
        end
        check("irq_after_evt", irq_cyc, evt_cyc + 1);
        check("evt_key3", dout, 32'h008);
        step(0, 3'd2, 0);
        check("key3_held", dout, 32'h008);

        // W1C landing on the same edge as a new key 5 event
        user_key[5] = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (m_deb[69] && !m_deb_d[69]) begin
                step(1, 3'd3, 32'h108);
                hit = 1'b1;
            end else begin
                step(0, 3'd3, 0);
            end
        end
        check("w1c_hit", {31'b0, hit}, 32'h1);
        step(0, 3'd3, 0);
        check("evt_set_wins", dout, 32'h020);
        check("irq_held", {31'b0, irq}, 32'h1);
        step(1, 3'd3, 32'h020);
        check("evt_cleared", dout, 32'h0);
        check("irq_lag", {31'b0, irq}, 32'h1);
        step(0, 3'd3, 0);
        check("irq_fall", {31'b0, irq}, 32'h0);

        // Key release and switch off
        user_key = '1;
        dip_sw[0] = 1'b1;
        for (int i = 0; i < 25; i++) step(0, 3'd3, 0);
        check("evt_release", dout, 32'h100);
        step(0, 3'd2, 0);
        check("key_released", dout, 32'h0);
        step(0, 3'd0, 0);
        check("sw_off", dout, 32'h0);

        // Reset in the middle of a key's history fill
        step(1, 3'd3, 32'h1ff);
        user_key[0] = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 3'd2, 0);
        do_reset();
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step(0, 3'd2, 0);
            if (lat < 0 && dout[0]) lat = i;
        end
        check("rst_mid_lat", {31'b0, lat >= 10 && lat <= 14}, 32'h1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        w;
            logic [2:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 9) == 0)
                user_key[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0)
                dip_sw[$urandom_range(0, 63)] ^= 1'b1;
            w = ($urandom_range(0, 7) == 0);
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            step(w, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
